// File: rtl/ctrl_qmem_arb_pkg.sv
// Shared types and defaults for the control-register qmem arbiter.
package ctrl_qmem_pkg;

  localparam int QAW_DEF = 22;
  localparam int QDW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_state_e;

  // Owning state for a given master index.
  function automatic own_state_e own_state_of(input logic idx);
    return idx ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/ctrl_qmem_arb_rr_pick.sv
// Two-way round-robin picker: one-hot grant, ptr names the favoured master on a tie.
module ctrl_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ctrl_qmem_arb.sv
// Two-master round-robin qmem arbiter in front of the control-register slave.
// Optional grant locking is enabled with `define CTRL_QMEM_ARB_LOCK_EN.
module ctrl_qmem_arb
  import ctrl_qmem_pkg::*;
#(
  parameter int QAW = QAW_DEF,
  parameter int QDW = QDW_DEF,
  parameter int QSW = QDW / 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [QAW-1:0] m0_adr,
  input  logic           m0_cs,
  input  logic           m0_we,
  input  logic [QSW-1:0] m0_sel,
  input  logic [QDW-1:0] m0_dat_w,
  input  logic           m0_lock,
  output logic [QDW-1:0] m0_dat_r,
  output logic           m0_ack,
  output logic           m0_err,
  input  logic [QAW-1:0] m1_adr,
  input  logic           m1_cs,
  input  logic           m1_we,
  input  logic [QSW-1:0] m1_sel,
  input  logic [QDW-1:0] m1_dat_w,
  input  logic           m1_lock,
  output logic [QDW-1:0] m1_dat_r,
  output logic           m1_ack,
  output logic           m1_err,
  output logic [QAW-1:0] s_adr,
  output logic           s_cs,
  output logic           s_we,
  output logic [QSW-1:0] s_sel,
  output logic [QDW-1:0] s_dat_w,
  input  logic [QDW-1:0] s_dat_r,
  input  logic           s_ack,
  input  logic           s_err
);

  own_state_e state_r, state_nxt_s;
  logic       rr_ptr_r, rd_vld_r, rd_own_r;
  logic [1:0] gnt_s;
  logic       owner_s, active_s, lock_s, cmp_s;

  ctrl_rr_pick u_pick (
    .req (({m1_cs, m0_cs})),
    .ptr (rr_ptr_r),
    .gnt (gnt_s)
  );

  // Current owner and whether its request is live (forced off while in reset)
  always_comb begin
    owner_s  = 1'b0;
    active_s = 1'b0;
    case (state_r)
      OWN_IDLE: begin owner_s = gnt_s[1]; active_s = |gnt_s; end
      OWN_M0:   begin owner_s = 1'b0;     active_s = m0_cs;  end
      OWN_M1:   begin owner_s = 1'b1;     active_s = m1_cs;  end
      default:  begin owner_s = 1'b0;     active_s = 1'b0;   end
    endcase
    active_s = active_s & rst_n;
  end

  // Slave request mux
  always_comb begin
    s_adr   = {QAW{1'b0}};
    s_cs    = 1'b0;
    s_we    = 1'b0;
    s_sel   = {QSW{1'b0}};
    s_dat_w = {QDW{1'b0}};
    if (active_s) begin
      s_cs    = 1'b1;
      s_adr   = owner_s ? m1_adr   : m0_adr;
      s_we    = owner_s ? m1_we    : m0_we;
      s_sel   = owner_s ? m1_sel   : m0_sel;
      s_dat_w = owner_s ? m1_dat_w : m0_dat_w;
    end else begin
      s_cs    = 1'b0;
    end
  end

`ifdef CTRL_QMEM_ARB_LOCK_EN
  // Owner's lock request
  always_comb begin
    lock_s = owner_s ? m1_lock : m0_lock;
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = m0_lock ^ m1_lock;
  assign lock_s        = 1'b0;
`endif

  assign cmp_s = active_s & s_ack;

  // Keep ownership while stalled or locked; otherwise fall back to IDLE
  always_comb begin
    state_nxt_s = OWN_IDLE;
    if (active_s && !(s_ack && !lock_s)) begin
      state_nxt_s = own_state_of(owner_s);
    end else begin
      state_nxt_s = OWN_IDLE;
    end
  end

  // Owner state, round-robin pointer and read-return tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= OWN_IDLE;
      rr_ptr_r <= 1'b0;
      rd_vld_r <= 1'b0;
      rd_own_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rd_vld_r <= cmp_s & ~s_we;
      if (cmp_s && !lock_s) begin
        rr_ptr_r <= ~owner_s;
      end
      if (cmp_s && !s_we) begin
        rd_own_r <= owner_s;
      end
    end
  end

  assign m0_ack   = s_ack & active_s & ~owner_s;
  assign m1_ack   = s_ack & active_s &  owner_s;
  assign m0_err   = s_err & active_s & ~owner_s;
  assign m1_err   = s_err & active_s &  owner_s;
  assign m0_dat_r = (rd_vld_r && !rd_own_r) ? s_dat_r : {QDW{1'b0}};
  assign m1_dat_r = (rd_vld_r &&  rd_own_r) ? s_dat_r : {QDW{1'b0}};

endmodule

// File: tb/tb_ctrl_qmem_arb.sv
// Self-checking bench for ctrl_qmem_arb: directed scenarios then random traffic vs a reference model.
module tb_ctrl_qmem_arb;

  localparam int QAW = 22;
  localparam int QDW = 32;
  localparam int QSW = 4;
  localparam int REG_UART_TX = 1;
  localparam int REG_TIMER   = 2;
`ifdef CTRL_QMEM_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [QAW-1:0] m0_adr = '0, m1_adr = '0;
  logic m0_cs = 1'b0, m1_cs = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [QSW-1:0] m0_sel = '0, m1_sel = '0;
  logic [QDW-1:0] m0_dat_w = '0, m1_dat_w = '0;
  logic m0_lock = 1'b0, m1_lock = 1'b0;
  logic [QDW-1:0] m0_dat_r, m1_dat_r;
  logic m0_ack, m1_ack, m0_err, m1_err;
  logic [QAW-1:0] s_adr;
  logic s_cs, s_we;
  logic [QSW-1:0] s_sel;
  logic [QDW-1:0] s_dat_w;
  logic [QDW-1:0] s_dat_r;
  logic s_ack, s_err;
  logic ack_en = 1'b0, err_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_qmem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr(m0_adr), .m0_cs(m0_cs), .m0_we(m0_we), .m0_sel(m0_sel), .m0_dat_w(m0_dat_w),
    .m0_lock(m0_lock), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_cs(m1_cs), .m1_we(m1_we), .m1_sel(m1_sel), .m1_dat_w(m1_dat_w),
    .m1_lock(m1_lock), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_cs(s_cs), .s_we(s_we), .s_sel(s_sel), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 * (i + 1) + 32'h0000_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Slave: combinational ack/err, registered read data, byte-masked writes
  logic [31:0] slv_mem [4];
  assign s_ack = s_cs & ack_en;
  assign s_err = s_cs & err_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) slv_mem[i] <= init_val(i);
      s_dat_r <= 32'h0;
    end else if (s_cs && s_ack) begin
      if (s_we) slv_mem[s_adr[3:2]] <= merge(slv_mem[s_adr[3:2]], s_dat_w, s_sel);
      else      s_dat_r <= slv_mem[s_adr[3:2]];
    end
  end

  // Reference model state
  int owner, rr, pend_own;
  logic [31:0] pend_dat;
  logic [31:0] ref_mem [4];
  int n_pass = 0, n_chk = 0;
  logic [1:0] obs_ack;
  logic [31:0] obs_dat0, obs_dat1;

  function automatic logic cs_of(input int i);   return (i == 1) ? m1_cs : m0_cs; endfunction
  function automatic logic we_of(input int i);   return (i == 1) ? m1_we : m0_we; endfunction
  function automatic logic lock_of(input int i); return (i == 1) ? m1_lock : m0_lock; endfunction
  function automatic logic [QAW-1:0] adr_of(input int i); return (i == 1) ? m1_adr : m0_adr; endfunction
  function automatic logic [3:0] sel_of(input int i);     return (i == 1) ? m1_sel : m0_sel; endfunction
  function automatic logic [31:0] dw_of(input int i);     return (i == 1) ? m1_dat_w : m0_dat_w; endfunction

  function automatic int winner();
    if (!rst_n) return -1;
    if (owner >= 0) return cs_of(owner) ? owner : -1;
    if (m0_cs && m1_cs) return rr;
    if (m0_cs) return 0;
    if (m1_cs) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; rr = 0; pend_own = -1; pend_dat = 32'h0;
    for (int i = 0; i < 4; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: inputs already driven at posedge+1; check at +4, then advance model
  task automatic step(input string tag);
    int w;
    logic [1:0] ix;
    #3;
    w = winner();
    obs_ack = {m1_ack, m0_ack};
    obs_dat0 = m0_dat_r;
    obs_dat1 = m1_dat_r;
    chk({tag, ":s_cs"}, {31'h0, s_cs}, {31'h0, w >= 0});
    chk({tag, ":acks"}, {30'h0, m1_ack, m0_ack},
        {30'h0, (w == 1) & ack_en, (w == 0) & ack_en});
    chk({tag, ":errs"}, {30'h0, m1_err, m0_err},
        {30'h0, (w == 1) & err_en, (w == 0) & err_en});
    chk({tag, ":dat_r0"}, m0_dat_r, (pend_own == 0) ? pend_dat : 32'h0);
    chk({tag, ":dat_r1"}, m1_dat_r, (pend_own == 1) ? pend_dat : 32'h0);
    if (w >= 0) begin
      chk({tag, ":s_adr"}, {10'h0, s_adr}, {10'h0, adr_of(w)});
      chk({tag, ":s_wr"}, {s_we, s_sel, s_dat_w[26:0]}, {we_of(w), sel_of(w), dw_of(w)[26:0]});
    end
    @(posedge clk);
    if (w >= 0 && ack_en) begin
      ix = adr_of(w)[3:2];
      if (we_of(w)) begin
        ref_mem[ix] = merge(ref_mem[ix], dw_of(w), sel_of(w));
        pend_own = -1;
      end else begin
        pend_own = w;
        pend_dat = ref_mem[ix];
      end
      if (LOCK && lock_of(w)) owner = w;
      else begin owner = -1; rr = 1 - w; end
    end else begin
      pend_own = -1;
      owner = w;
    end
    #1;
  endtask

  task automatic drive(input int i, input logic cs, input logic we, input int idx,
                       input logic [31:0] dat, input logic lock);
    if (i == 0) begin
      m0_cs = cs; m0_we = we; m0_adr = {18'h20000, 2'(idx), 2'b00};
      m0_dat_w = dat; m0_sel = 4'hF; m0_lock = lock;
    end else begin
      m1_cs = cs; m1_we = we; m1_adr = {18'h20000, 2'(idx), 2'b00};
      m1_dat_w = dat; m1_sel = 4'hF; m1_lock = lock;
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst:s_cs", {31'h0, s_cs}, 32'h0);
    chk("rst:s_bus", {s_we, s_sel, s_adr[21:0], 5'h0}, 32'h0);
    chk("rst:m_out", {28'h0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
    chk("rst:dat_r", m0_dat_r | m1_dat_r, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    step("idle");

    // m0 reads the timer, acked immediately; data returns next cycle
    ack_en = 1'b1;
    drive(0, 1'b1, 1'b0, REG_TIMER, 32'h0, 1'b0);
    step("timer_rd");
    chk("timer_ack", {30'h0, obs_ack}, 32'h1);
    drive(0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    step("timer_ret");
    chk("timer_dat0", obs_dat0, init_val(REG_TIMER));
    chk("timer_dat1", obs_dat1, 32'h0);

    // m1 transfer so the pointer returns to m0, then alternating writes
    drive(1, 1'b1, 1'b0, 3, 32'h0, 1'b0);
    step("m1_rd");
    drive(0, 1'b1, 1'b1, 0, 32'hAAAA_0000, 1'b0);
    drive(1, 1'b1, 1'b1, 3, 32'h5555_0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      m0_dat_w = 32'hAAAA_0000 + 32'(i);
      m1_dat_w = 32'h5555_0000 + 32'(i);
      step("alt");
      chk("alt_order", {30'h0, obs_ack}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Long UART stall by m0 while m1 waits
    ack_en = 1'b0;
    drive(0, 1'b1, 1'b1, REG_UART_TX, 32'h0000_0041, 1'b0);
    drive(1, 1'b1, 1'b0, REG_TIMER, 32'h0, 1'b0);
    for (int i = 0; i < 434; i++) step("stall");
    ack_en = 1'b1;
    step("stall_end");
    chk("stall_m0", {30'h0, obs_ack}, 32'h1);
    drive(0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    step("after_stall");
    chk("stall_m1", {30'h0, obs_ack}, 32'h2);

    // m0 aborts after 3 stalled cycles; m1 takes the next cycle
    ack_en = 1'b0;
    drive(0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b1, 2, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) step("abort_stall");
    drive(0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    ack_en = 1'b1;
    step("abort");
    chk("abort_none", {30'h0, obs_ack}, 32'h0);
    step("abort_m1");
    chk("abort_m1_gnt", {30'h0, obs_ack}, 32'h2);
    drive(0, 1'b1, 1'b1, 0, 32'h0000_0099, 1'b0);
    step("rr_kept");
    chk("rr_kept_m0", {30'h0, obs_ack}, 32'h1);

`ifdef CTRL_QMEM_ARB_LOCK_EN
    // Locked m1 burst keeps the grant while m0 waits
    for (int i = 0; i < 4; i++) begin
      m1_lock = (i < 3);
      step("lock");
      chk("lock_m1", {30'h0, obs_ack}, 32'h2);
    end
    step("lock_rel");
    chk("lock_rel_m0", {30'h0, obs_ack}, 32'h1);
`endif

    // Reset during an m1 stalled read
    drive(0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 1, 32'h0, 1'b0);
    ack_en = 1'b0;
    step("pre_rst");
    step("pre_rst2");
    drive(0, 1'b1, 1'b0, 2, 32'h0, 1'b0);
    ack_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_s_cs", {31'h0, s_cs}, 32'h0);
    chk("midrst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst");
    chk("post_rst_m0", {30'h0, obs_ack}, 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      m0_cs = ($urandom_range(0, 3) != 0); m1_cs = ($urandom_range(0, 3) != 0);
      m0_we = $urandom_range(0, 1) == 1;  m1_we = $urandom_range(0, 1) == 1;
      m0_adr = {18'h20000, 2'($urandom_range(0, 3)), 2'b00};
      m1_adr = {18'h20000, 2'($urandom_range(0, 3)), 2'b00};
      m0_sel = 4'($urandom_range(0, 15)); m1_sel = 4'($urandom_range(0, 15));
      m0_dat_w = $urandom; m1_dat_w = $urandom;
      m0_lock = ($urandom_range(0, 3) == 0); m1_lock = ($urandom_range(0, 3) == 0);
      ack_en = ($urandom_range(0, 2) != 0);
      err_en = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
